// File: rtl/seq_direction_decoder.sv
// Decodes a 2-bit cyclic count stream into up/down step pulses, a wrapping position
// accumulator and a saturating count of illegal (delta 2) jumps.
module seq_direction_decoder #(
  parameter int POS_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       in,
  input  logic             in_valid,
  input  logic             clr,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic [POS_W-1:0] position,
  output logic [ERR_W-1:0] err_count,
  output logic             locked
);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    TRACK      = 2'd1,
    RESYNC     = 2'd2
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_t           state_r, state_next_s;
  logic [1:0]       prev_r, prev_next_s;
  logic [1:0]       delta_s;
  logic [POS_W-1:0] position_r, position_next_s;
  logic [ERR_W-1:0] err_count_r, err_count_next_s;
  logic             step_r, step_next_s;
  logic             err_r, err_next_s;
  logic             dir_r, dir_next_s;
  logic             locked_r, locked_next_s;

  assign delta_s = in - prev_r;

  // Next-state and next-output decode; clr behaves as a soft reset ahead of sampling.
  always_comb begin
    state_next_s     = state_r;
    prev_next_s      = prev_r;
    position_next_s  = position_r;
    err_count_next_s = err_count_r;
    step_next_s      = 1'b0;
    err_next_s       = 1'b0;
    dir_next_s       = dir_r;
    if (clr) begin
      state_next_s     = WAIT_FIRST;
      prev_next_s      = 2'd0;
      position_next_s  = {POS_W{1'b0}};
      err_count_next_s = {ERR_W{1'b0}};
      dir_next_s       = 1'b0;
    end else if (in_valid) begin
      case (state_r)
        WAIT_FIRST, RESYNC: begin
          // Reference-only sample: even a 2-away value is accepted silently.
          prev_next_s  = in;
          state_next_s = TRACK;
        end
        TRACK: begin
          prev_next_s = in;
          case (delta_s)
            2'd0: begin
              step_next_s = 1'b0;
            end
            2'd1: begin
              step_next_s     = 1'b1;
              dir_next_s      = 1'b0;
              position_next_s = position_r + POS_W'(1);
            end
            2'd3: begin
              step_next_s     = 1'b1;
              dir_next_s      = 1'b1;
              position_next_s = position_r - POS_W'(1);
            end
            2'd2: begin
              err_next_s   = 1'b1;
              state_next_s = RESYNC;
              if (err_count_r != ERR_MAX) begin
                err_count_next_s = err_count_r + ERR_W'(1);
              end else begin
                err_count_next_s = err_count_r;
              end
            end
            default: begin
              step_next_s = 1'b0;
            end
          endcase
        end
        default: begin
          state_next_s = WAIT_FIRST;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
    locked_next_s = (state_next_s == TRACK);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= WAIT_FIRST;
      prev_r      <= 2'd0;
      position_r  <= {POS_W{1'b0}};
      err_count_r <= {ERR_W{1'b0}};
      step_r      <= 1'b0;
      err_r       <= 1'b0;
      dir_r       <= 1'b0;
      locked_r    <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      prev_r      <= prev_next_s;
      position_r  <= position_next_s;
      err_count_r <= err_count_next_s;
      step_r      <= step_next_s;
      err_r       <= err_next_s;
      dir_r       <= dir_next_s;
      locked_r    <= locked_next_s;
    end
  end

  assign step      = step_r;
  assign err       = err_r;
  assign dir       = dir_r;
  assign position  = position_r;
  assign err_count = err_count_r;
  assign locked    = locked_r;

endmodule

// File: tb/tb_seq_direction_decoder.sv
// Directed bench for seq_direction_decoder: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_seq_direction_decoder;

  typedef struct {
    logic       step;
    logic       err;
    logic       dir;
    logic [7:0] pos;
    logic [3:0] errc;
    logic       locked;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [1:0] in;
  logic       in_valid;
  logic       clr;
  logic       step;
  logic       dir;
  logic       err;
  logic [7:0] position;
  logic [3:0] err_count;
  logic       locked;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_seen   = 0;

  seq_direction_decoder #(.POS_W(8), .ERR_W(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .in_valid (in_valid),
    .clr      (clr),
    .step     (step),
    .dir      (dir),
    .err      (err),
    .position (position),
    .err_count(err_count),
    .locked   (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus and queue the outputs expected after that edge.
  task automatic drive(input logic rv, input logic cv, input logic vv, input logic [1:0] iv,
                       input logic es, input logic ee, input logic ed, input logic [7:0] ep,
                       input logic [3:0] ec, input logic el);
    exp_t e;
    reset = rv; clr = cv; in_valid = vv; in = iv;
    @(posedge clk);
    #1;
    e.step = es; e.err = ee; e.dir = ed; e.pos = ep; e.errc = ec; e.locked = el;
    exp_q.push_back(e);
  endtask

  // Monitor: registered outputs are compared mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_seen++;
      n_checks++;
      if (step !== e.step || err !== e.err || dir !== e.dir || position !== e.pos ||
          err_count !== e.errc || locked !== e.locked) begin
        n_fail++;
        $display("FAIL cycle%0d: got step=%b err=%b dir=%b pos=%h errc=%h locked=%b, expected step=%b err=%b dir=%b pos=%h errc=%h locked=%b",
                 n_seen, step, err, dir, position, err_count, locked,
                 e.step, e.err, e.dir, e.pos, e.errc, e.locked);
      end
    end
  end

  initial begin
    reset = 1'b0; clr = 1'b0; in_valid = 1'b0; in = 2'd0;
    // Reset state
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    // Up count 0,1,2,3,0
    drive(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'h01, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'h02, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 8'h03, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 8'h04, 4'd0, 1'b1);
    // Down count 3,2,1,0 twice: 4 -> 0 -> 0xFC
    drive(1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 8'h03, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 8'h02, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 8'h01, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'h00, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 8'hFF, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 8'hFE, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 8'hFD, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 8'hFC, 4'd0, 1'b1);
    // in_valid low: a 2-away value must be ignored
    drive(1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 8'hFC, 4'd0, 1'b1);
    // prev=1, jump to 3, resync on 1, then step to 2
    drive(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 8'hFD, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 8'hFD, 4'd1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'hFD, 4'd1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'hFE, 4'd1, 1'b1);
    // Delta 0
    drive(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 8'hFE, 4'd1, 1'b1);
    // 20 illegal jumps alternating 0/2; count saturates at 15
    for (int k = 1; k <= 20; k++) begin
      drive(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 8'hFE, 4'((k + 1 > 15) ? 15 : k + 1), 1'b0);
      drive(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 8'hFE, 4'((k + 1 > 15) ? 15 : k + 1), 1'b1);
    end
    // clr mid-stream with a sample present, then reference-only sample
    drive(1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 8'h01, 4'd0, 1'b1);
    // Up steps through 127 -> 0x80 and 255 -> 0x00
    for (int j = 1; j <= 255; j++) begin
      drive(1'b1, 1'b0, 1'b1, 2'(j), 1'b1, 1'b0, 1'b0, 8'(1 + j), 4'd0, 1'b1);
    end
    // Down from 0 wraps to 0xFF (prev is 3)
    drive(1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 8'hFF, 4'd0, 1'b1);
    // Single-cycle reset mid-stream; next sample is reference only; held input gives no steps
    drive(1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 8'h01, 4'd0, 1'b1);
    // Reset beats clr and in_valid
    drive(1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_direction_decoder.md
SEQ_DIRECTION_DECODER -- requirements
Module: seq_direction_decoder

Interface
REQ-001 SHALL have parameter POS_W, default 8: width of the signed position accumulator.
REQ-002 SHALL have parameter ERR_W, default 4: width of the saturating error counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on posedge clk only.
REQ-005 in  input  2  observed 2-bit count value, binary 0..3.
REQ-006 in_valid  input  1  in is sampled this cycle when high.
REQ-007 clr  input  1  synchronous clear of position, error count and tracking state.
REQ-008 step  output  1  one-cycle pulse: a legal +1 or -1 step was decoded.
REQ-009 dir  output  1  direction of last legal step: 0 = up (+1 mod 4), 1 = down (-1 mod 4).
REQ-010 err  output  1  one-cycle pulse: illegal jump (delta 2) detected.
REQ-011 position  output  POS_W  two's-complement step accumulator.
REQ-012 err_count  output  ERR_W  count of illegal jumps, saturating.
REQ-013 locked  output  1  high while in TRACK state.

Function
REQ-014 SHALL implement FSM states WAIT_FIRST, TRACK, RESYNC; all outputs registered.
REQ-015 SHALL register one reference sample prev[1:0].
REQ-016 WAIT_FIRST: on in_valid, load prev <= in, go TRACK; no step, no err.
REQ-017 TRACK: on in_valid, compute delta = (in - prev) mod 4, then load prev <= in.
REQ-018 delta 0: no step, no err; dir and position unchanged.
REQ-019 delta 1: step=1, dir=0, position += 1.
REQ-020 delta 3: step=1, dir=1, position -= 1.
REQ-021 delta 2: err=1, err_count += 1 (held at 2^ERR_W-1 once reached), position and dir unchanged; go RESYNC.
REQ-022 RESYNC: on in_valid, load prev <= in, go TRACK; no step, no err, even if the sample is itself 2 away.
REQ-023 in_valid low: no state, prev, or output changes except step/err deasserting.
REQ-024 step and err SHALL be high for exactly the one cycle after the qualifying sample edge (latency 1 clk); never both high together.
REQ-025 position SHALL wrap modulo 2^POS_W in both directions (max+1 -> min, min-1 -> max); no overflow flag.
REQ-026 locked = 1 only in TRACK.
REQ-027 clr=1 (reset high): position=0, err_count=0, step=0, err=0, dir=0, state WAIT_FIRST; in/in_valid that cycle ignored.

Reset
REQ-028 reset low at a clk edge: state WAIT_FIRST, prev=0, position=0, err_count=0, step=0, err=0, dir=0, locked=0.
REQ-029 reset SHALL take priority over clr and in_valid.
REQ-030 reset asserted mid-operation SHALL discard prev; first sample afterwards is a reference only (REQ-016).
REQ-031 No asynchronous path from reset to any flop.

Verification
REQ-032 Reset, then in_valid with in=0,1,2,3,0 -> first sample no step; then 4 step pulses, dir=0, position=4, locked=1 after first sample.
REQ-033 From TRACK prev=0, in=3,2,1,0 -> 4 step pulses, dir=1, position decreases by 4; POS_W=8 from 0 gives position=0xFC.
REQ-034 prev=1, in=3 -> err pulse, err_count +1, locked=0; next in=1 -> no step/err, locked=1; next in=2 -> step, dir=0.
REQ-035 Repeated illegal jumps (0,2 alternating via RESYNC) 20 times with ERR_W=4 -> err_count saturates at 15, err still pulses each time.
REQ-036 position=127 then one up step -> position=0x80; clr mid-stream -> position=0, err_count=0, next sample reference only.
REQ-037 reset low for one cycle during stream of in_valid -> all outputs zero next cycle; held in_valid with constant in -> no step pulses.
